// File: rtl/ppe_grant_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppe_grant_ctrl_pkg
//  Description : Shared sizes, FSM state encoding and pointer-mode encoding
//                for the programmable priority encoder grant path.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppe_grant_ctrl_pkg;

    // Requester count, index width and burst-length field width
    localparam int W  = 512;
    localparam int IW = 9;
    localparam int BW = 4;

    // Pointer source selection
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Grant FSM states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/decoder_9_to_512.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_9_to_512
//  Description : Combinational index-to-one-hot decoder; the inverse of the
//                512-to-9 priority encoder on the request side.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_9_to_512
    import ppe_grant_ctrl_pkg::*;
(
    input  logic [IW-1:0] idx,
    output logic [W-1:0]  onehot
);

    // One comparator per output bit; exactly one bit is set for any index
    for (genvar i = 0; i < W; i++) begin : g_onehot
        assign onehot[i] = (idx == IW'(i));
    end

endmodule
`default_nettype wire

// File: rtl/ppe_grant_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ppe_grant_ctrl
//  Description : Sequential grant side of the priority encoder path. Drives
//                the priority pointer, captures the winning index, holds a
//                registered one-hot grant for a programmable burst under a
//                valid/ready handshake and advances the round-robin pointer
//                when the burst completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppe_grant_ctrl
    import ppe_grant_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [IW-1:0] prog_ptr,
    input  logic [BW-1:0] burst_len,
    output logic [IW-1:0] p_enc,
    input  logic [IW-1:0] enc_value,
    input  logic          enc_valid,
    output logic [W-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    input  logic          gnt_ready,
    output logic          gnt_last,
    output logic          busy
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_gnt;
    logic [W-1:0]  w_gnt_nxt;
    logic [IW-1:0] r_gnt_idx;
    logic [IW-1:0] w_gnt_idx_nxt;
    logic [BW-1:0] r_beats;
    logic [BW-1:0] w_beats_nxt;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] w_rr_ptr_nxt;
    logic [W-1:0]  w_dec;

    decoder_9_to_512 u_dec (
        .idx    (enc_value),
        .onehot (w_dec)
    );

    // Pointer to the encoder: programmed value in fixed mode, else round-robin
    assign p_enc = (mode == MODE_FIXED) ? prog_ptr : r_rr_ptr;

    // State, grant, index, beat counter and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_beats   <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_beats   <= w_beats_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
        end
    end

    // Next-state logic: capture in IDLE, count accepted beats in GRANT
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_beats_nxt   = r_beats;
        w_rr_ptr_nxt  = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (enc_valid) begin
                    w_state_nxt   = GRANT;
                    w_gnt_nxt     = w_dec;
                    w_gnt_idx_nxt = enc_value;
                    // A zero burst length still delivers one beat
                    w_beats_nxt   = (burst_len == '0) ? BW'(1) : burst_len;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    if (r_beats == BW'(1)) begin
                        w_state_nxt  = IDLE;
                        w_gnt_nxt    = '0;
                        w_beats_nxt  = '0;
                        // Natural IW-bit overflow wraps 511 back to 0
                        w_rr_ptr_nxt = r_gnt_idx + IW'(1);
                    end else begin
                        w_beats_nxt  = r_beats - BW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_beats_nxt = '0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = (r_state == GRANT);
    assign busy      = (r_state != IDLE);
    assign gnt_last  = (r_state == GRANT) && (r_beats == BW'(1));

endmodule
`default_nettype wire

// File: doc/ppe_grant_ctrl.md
Name: ppe_grant_ctrl

Overview:
- Sequential grant side of the programmable priority encoder path.
- Drives the 9-bit priority pointer into the encoder and captures the encoder's winning index and valid.
- Decodes the index into a registered one-hot 512-bit grant, held for a programmable burst under a valid/ready handshake.
- Advances the round-robin pointer on burst completion. Sits between the encoder and the 512 requesters/downstream consumer.

Parameters:
- W, 512, number of requesters / grant vector width.
- IW, 9, index width, log2(W).
- BW, 4, burst-length field width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = round-robin pointer, 1 = fixed pointer from prog_ptr.
- prog_ptr  in  IW  programmed priority pointer used when mode=1.
- burst_len  in  BW  beats per grant; 0 is treated as 1.
- p_enc  out  IW  priority pointer to the encoder.
- enc_value  in  IW  winning index from the encoder.
- enc_valid  in  1  encoder found at least one request.
- gnt  out  W  registered one-hot grant.
- gnt_idx  out  IW  registered index of the current grant.
- gnt_valid  out  1  grant beat offered.
- gnt_ready  in  1  downstream accepts the current beat.
- gnt_last  out  1  current beat is the final beat of the burst.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - rr_ptr=0, state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, gnt_last=0, busy=0, beat counter=0.
  - p_enc = mode ? prog_ptr : 0.
- p_enc is combinational: mode ? prog_ptr : rr_ptr. Its value is stable within a cycle given stable inputs.
- FSM states: IDLE and GRANT.
- IDLE:
  - If enc_valid=1 at edge N:
    - Capture gnt_idx=enc_value.
    - Set gnt = one-hot(enc_value).
    - Load beats = (burst_len==0 ? 1 : burst_len).
    - Go to GRANT, so gnt_valid=1 from cycle N+1 (latency 1).
  - If enc_valid=0, stay in IDLE with outputs at 0.
- GRANT:
  - gnt_valid=1 and busy=1. gnt and gnt_idx hold stable for the whole burst.
  - gnt_last = (remaining beats == 1).
  - A beat completes on gnt_valid & gnt_ready, which decrements the remaining count.
  - With gnt_ready=0, all outputs hold indefinitely.
  - Changes to enc_value, enc_valid, burst_len or mode during GRANT do not affect the grant in progress. burst_len is sampled only at capture.
  - When the last beat completes at edge M:
    - rr_ptr <= gnt_idx+1 modulo W (511 wraps to 0; natural IW-bit overflow).
    - gnt <= 0, gnt_valid <= 0, state <= IDLE.
- Pointer updates:
  - rr_ptr updates on every burst completion regardless of mode.
  - In mode=1, p_enc ignores rr_ptr.
- Arbitration spacing: IDLE at M+1 presents the new p_enc, so the earliest next grant is gnt_valid at M+2. This gives a guaranteed one-cycle bubble and round-robin fairness.
- Invariant: gnt has at most one bit set. gnt=0 whenever gnt_valid=0.
- Reset mid-burst: all state is cleared immediately, and no pointer update occurs.
- enc_value is trusted to be in range (IW bits index exactly W=512 entries).

Decomposition:
- Shared package:
  - Constants W, IW, BW.
  - State encoding IDLE/GRANT.
  - Mode encoding (MODE_RR=0, MODE_FIXED=1).
- Sub-module decoder_9_to_512: combinational index-to-one-hot decoder, the inverse of the existing 512-to-9 encoder.
  - Its output is registered in ppe_grant_ctrl at capture.

Test Plan:
- Reset + single grant:
  - Stimulus: mode=0, enc_valid=1, enc_value=5, burst_len=1, gnt_ready=1.
  - Required response: the cycle after capture, gnt=1<<5, gnt_idx=5, gnt_last=1. Next cycle gnt_valid=0, p_enc=6.
- Wrap-around:
  - Stimulus: enc_value=511, burst_len=1.
  - Required response: after completion, p_enc=0.
- Burst with backpressure:
  - Stimulus: burst_len=3, gnt_ready pattern 1,0,0,1,1.
  - Required response: gnt_valid high for exactly 5 cycles. gnt_last high only in the 5th. gnt stable throughout. enc_value changes mid-burst are ignored.
- burst_len=0:
  - Required response: behaves as a 1-beat burst.
- Fixed mode:
  - Stimulus: mode=1, prog_ptr=300, grant idx 310 completes.
  - Required response: p_enc remains 300. Switching to mode=0 then gives p_enc=311.
- Async reset mid-burst:
  - Stimulus: rst_n low in GRANT after 1 of 4 beats.
  - Required response: immediately gnt=0, gnt_valid=0, busy=0, rr_ptr=0 (p_enc=0 in mode=0). After release, the first grant needs 1 cycle of latency.
